// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: request, stack-pointer, memory bus and result signals of the stack sequencer
interface stack_sequencer_if;
  logic        start;
  logic        op_push;
  logic [1:0]  op_count;
  logic [7:0]  byte0_in;
  logic [7:0]  byte1_in;
  logic [7:0]  byte2_in;
  logic [7:0]  sp_in;
  logic        rdy;
  logic [7:0]  db_in;
  logic [15:0] address_out;
  logic [7:0]  dout;
  logic        we;
  logic        re;
  logic        sp_increment;
  logic        sp_decrement;
  logic        busy;
  logic        done;
  logic [7:0]  res0;
  logic [7:0]  res1;
  logic [7:0]  res2;
  modport master (
    output start, op_push, op_count, byte0_in, byte1_in, byte2_in, sp_in, rdy, db_in,
    input  address_out, dout, we, re, sp_increment, sp_decrement, busy, done, res0, res1, res2
  );
  modport slave (
    input  start, op_push, op_count, byte0_in, byte1_in, byte2_in, sp_in, rdy, db_in,
    output address_out, dout, we, re, sp_increment, sp_decrement, busy, done, res0, res1, res2
  );
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: runs 1-3 back-to-back push or pull cycles on the page-1 stack
module stack_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input logic          clk,
  input logic          reset_n,
  stack_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  state_t      state_q;
  logic        push_q;
  logic [1:0]  cnt_q;
  logic [1:0]  k_q;
  logic [15:0] addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  byte_q [3];
  logic [7:0]  res_q [3];
  logic        step;
  logic        commit;
  logic        last;
  logic [15:0] addr_d;
  logic [7:0]  byte_k;
  // Current-step decode: pulls address SP+1 because the pointer names the next free slot
  always_comb begin
    step   = state_q == STEP;
    commit = step && bus.rdy;
    last   = k_q == cnt_q - 2'd1;
    addr_d = {STACK_PAGE, push_q ? bus.sp_in : bus.sp_in + 8'd1};
    byte_k = k_q == 2'd0 ? byte_q[0] : k_q == 2'd1 ? byte_q[1] : byte_q[2];
  end
  // Outside STEP the bus shows the last committed address/data so it never glitches in IDLE
  assign bus.address_out  = step ? addr_d : addr_q;
  assign bus.dout         = step && push_q ? byte_k : dout_q;
  assign bus.we           = step && push_q;
  assign bus.re           = step && !push_q;
  assign bus.sp_decrement = commit && push_q;
  assign bus.sp_increment = commit && !push_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = state_q == DONE;
  assign bus.res0         = res_q[0];
  assign bus.res1         = res_q[1];
  assign bus.res2         = res_q[2];
  // Sequencer FSM: capture request, advance one byte per ready cycle, pulse done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      cnt_q   <= 2'd0;
      k_q     <= 2'd0;
      addr_q  <= 16'd0;
      dout_q  <= 8'd0;
      byte_q  <= '{default: 8'd0};
      res_q   <= '{default: 8'd0};
    end else if (state_q == IDLE) begin
      if (bus.start && bus.op_count != 2'd0) begin
        state_q <= STEP;
        push_q  <= bus.op_push;
        cnt_q   <= bus.op_count;
        k_q     <= 2'd0;
        byte_q  <= '{bus.byte0_in, bus.byte1_in, bus.byte2_in};
      end
    end else if (commit) begin
      addr_q <= addr_d;
      if (push_q) dout_q <= byte_k;
      else res_q[k_q] <= bus.db_in;
      k_q     <= k_q + 2'd1;
      state_q <= last ? DONE : STEP;
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end
  end
endmodule
